// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_mp
// Brief    : Multi-port register file, two prioritised write ports, registered
//            bypassed reads and a per-register busy scoreboard.
// Revision : 1.0
// ============================================================================
module reg_file_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     en_i,
  input  logic [NUM_RD*ADDR_W-1:0] rd_sel_i,
  output logic [NUM_RD*DATA_W-1:0] rd_data_o,
  output logic [NUM_RD-1:0]        rd_rdy_o,
  input  logic                     wr0_en_i,
  input  logic [ADDR_W-1:0]        wr0_sel_i,
  input  logic [DATA_W-1:0]        wr0_data_i,
  input  logic                     wr1_en_i,
  input  logic [ADDR_W-1:0]        wr1_sel_i,
  input  logic [DATA_W-1:0]        wr1_data_i,
  input  logic                     sb_set_en_i,
  input  logic [ADDR_W-1:0]        sb_set_sel_i
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]        regs_q [DEPTH];
  logic [DEPTH-1:0]         busy_q, busy_d;
  logic [NUM_RD*DATA_W-1:0] rd_data_q, rd_data_d;
  logic [NUM_RD-1:0]        rd_rdy_q, rd_rdy_d;
  logic                     wr0_act, wr1_act, sb_act;

  // Register 0 is never a real destination, so qualify every update here.
  assign wr0_act = wr0_en_i    && (wr0_sel_i    != '0);
  assign wr1_act = wr1_en_i    && (wr1_sel_i    != '0);
  assign sb_act  = sb_set_en_i && (sb_set_sel_i != '0);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int r = 0; r < DEPTH; r++) begin
        regs_q[r] <= '0;
      end
    end else begin
      if (wr0_act) regs_q[wr0_sel_i] <= wr0_data_i;
      if (wr1_act) regs_q[wr1_sel_i] <= wr1_data_i;
    end
  end

  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < DEPTH; r++) begin
      if (sb_act && (sb_set_sel_i == ADDR_W'(r))) begin
        busy_d[r] = 1'b1;
      end else if ((wr0_act && (wr0_sel_i == ADDR_W'(r))) ||
                   (wr1_act && (wr1_sel_i == ADDR_W'(r)))) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] sel;
    logic              is_zero, hit0, hit1, set_hit;

    assign sel     = rd_sel_i[i*ADDR_W +: ADDR_W];
    assign is_zero = (sel == '0);
    assign hit0    = wr0_act && (wr0_sel_i == sel);
    assign hit1    = wr1_act && (wr1_sel_i == sel);
    assign set_hit = sb_act  && (sb_set_sel_i == sel);

    // rdy mirrors the post-edge busy state so it always matches the captured data.
    assign rd_data_d[i*DATA_W +: DATA_W] = is_zero ? '0         :
                                           hit1    ? wr1_data_i :
                                           hit0    ? wr0_data_i :
                                                     regs_q[sel];
    assign rd_rdy_d[i] = is_zero | (~set_hit & (hit0 | hit1 | ~busy_q[sel]));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_q    <= '0;
      rd_data_q <= '0;
      rd_rdy_q  <= '1;
    end else begin
      busy_q <= busy_d;
      if (en_i) begin
        rd_data_q <= rd_data_d;
        rd_rdy_q  <= rd_rdy_d;
      end
    end
  end

  assign rd_data_o = rd_data_q;
  assign rd_rdy_o  = rd_rdy_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_mp
// Brief    : Scoreboard bench for reg_file_mp (default and 4-port/16-bit builds).
// Revision : 1.0
// ============================================================================
module tb_reg_file_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default build: DATA_W=32, ADDR_W=5, NUM_RD=2
  logic        a_reset, a_en, a_w0e, a_w1e, a_sbe;
  logic [9:0]  a_sel;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_rdy;
  logic [4:0]  a_w0s, a_w1s, a_sbs;
  logic [31:0] a_w0d, a_w1d;

  // Small build: DATA_W=16, ADDR_W=4, NUM_RD=4
  logic        b_reset, b_en, b_w0e, b_w1e, b_sbe;
  logic [15:0] b_sel;
  logic [63:0] b_rd_data;
  logic [3:0]  b_rd_rdy;
  logic [3:0]  b_w0s, b_w1s, b_sbs;
  logic [15:0] b_w0d, b_w1d;

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) u_dut_a (
    .clk_i(clk), .reset_i(a_reset), .en_i(a_en), .rd_sel_i(a_sel),
    .rd_data_o(a_rd_data), .rd_rdy_o(a_rd_rdy),
    .wr0_en_i(a_w0e), .wr0_sel_i(a_w0s), .wr0_data_i(a_w0d),
    .wr1_en_i(a_w1e), .wr1_sel_i(a_w1s), .wr1_data_i(a_w1d),
    .sb_set_en_i(a_sbe), .sb_set_sel_i(a_sbs)
  );

  reg_file_mp #(.DATA_W(16), .ADDR_W(4), .NUM_RD(4)) u_dut_b (
    .clk_i(clk), .reset_i(b_reset), .en_i(b_en), .rd_sel_i(b_sel),
    .rd_data_o(b_rd_data), .rd_rdy_o(b_rd_rdy),
    .wr0_en_i(b_w0e), .wr0_sel_i(b_w0s), .wr0_data_i(b_w0d),
    .wr1_en_i(b_w1e), .wr1_sel_i(b_w1s), .wr1_data_i(b_w1d),
    .sb_set_en_i(b_sbe), .sb_set_sel_i(b_sbs)
  );

  typedef struct {
    bit          is_b;
    logic [63:0] data;
    logic [3:0]  rdy;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference state for the default build
  logic [31:0] m_regs [32];
  bit          m_busy [32];
  logic [31:0] m_ed   [2];
  logic        m_er   [2];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick_and_check();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.is_b) begin
        check_eq({e.tag, "_data"}, b_rd_data, e.data);
        check_eq({e.tag, "_rdy"}, {60'd0, b_rd_rdy}, {60'd0, e.rdy});
      end else begin
        check_eq({e.tag, "_data"}, a_rd_data, e.data);
        check_eq({e.tag, "_rdy"}, {62'd0, a_rd_rdy}, {60'd0, e.rdy});
      end
    end
  endtask

  task automatic step_a(input string tag, input logic rst, input logic en,
                        input logic w0e, input logic [4:0] w0s, input logic [31:0] w0d,
                        input logic w1e, input logic [4:0] w1s, input logic [31:0] w1d,
                        input logic sbe, input logic [4:0] sbs,
                        input logic [4:0] s1, input logic [4:0] s0);
    exp_t        e;
    logic [4:0]  s;
    logic        a0, a1, as, h0, h1;
    a_reset = rst; a_en = en; a_sel = {s1, s0};
    a_w0e = w0e; a_w0s = w0s; a_w0d = w0d;
    a_w1e = w1e; a_w1s = w1s; a_w1d = w1d;
    a_sbe = sbe; a_sbs = sbs;
    if (rst) begin
      for (int p = 0; p < 2; p++) begin m_ed[p] = '0; m_er[p] = 1'b1; end
      for (int r = 0; r < 32; r++) begin m_regs[r] = '0; m_busy[r] = 1'b0; end
    end else begin
      a0 = w0e && (w0s != 0);
      a1 = w1e && (w1s != 0);
      as = sbe && (sbs != 0);
      if (en) begin
        for (int p = 0; p < 2; p++) begin
          s  = (p == 1) ? s1 : s0;
          h0 = a0 && (w0s == s);
          h1 = a1 && (w1s == s);
          if (s == 0) begin
            m_ed[p] = '0; m_er[p] = 1'b1;
          end else begin
            m_ed[p] = h1 ? w1d : (h0 ? w0d : m_regs[s]);
            m_er[p] = (as && sbs == s) ? 1'b0 : ((h0 || h1) ? 1'b1 : !m_busy[s]);
          end
        end
      end
      if (a0) m_regs[w0s] = w0d;
      if (a1) m_regs[w1s] = w1d;
      for (int r = 1; r < 32; r++) begin
        if (as && sbs == 5'(r)) m_busy[r] = 1'b1;
        else if ((a0 && w0s == 5'(r)) || (a1 && w1s == 5'(r))) m_busy[r] = 1'b0;
      end
    end
    e.is_b = 1'b0;
    e.data = {m_ed[1], m_ed[0]};
    e.rdy  = {2'b00, m_er[1], m_er[0]};
    e.tag  = tag;
    sb_q.push_back(e);
    tick_and_check();
  endtask

  task automatic step_b(input string tag, input logic rst, input logic en,
                        input logic w0e, input logic [3:0] w0s, input logic [15:0] w0d,
                        input logic w1e, input logic [3:0] w1s, input logic [15:0] w1d,
                        input logic sbe, input logic [3:0] sbs, input logic [15:0] sel,
                        input logic [63:0] exp_d, input logic [3:0] exp_r);
    exp_t e;
    b_reset = rst; b_en = en; b_sel = sel;
    b_w0e = w0e; b_w0s = w0s; b_w0d = w0d;
    b_w1e = w1e; b_w1s = w1s; b_w1d = w1d;
    b_sbe = sbe; b_sbs = sbs;
    e.is_b = 1'b1; e.data = exp_d; e.rdy = exp_r; e.tag = tag;
    sb_q.push_back(e);
    tick_and_check();
  endtask

  initial begin
    b_reset = 1'b1; b_en = 1'b0; b_sel = '0;
    b_w0e = 1'b0; b_w0s = '0; b_w0d = '0;
    b_w1e = 1'b0; b_w1s = '0; b_w1d = '0;
    b_sbe = 1'b0; b_sbs = '0;
    #1;

    // tag, rst, en, w0e, w0s, w0d, w1e, w1s, w1d, sbe, sbs, sel1, sel0
    step_a("rst0",      1, 0, 0, 0, 0,            0, 0, 0,    0, 0, 0, 0);
    step_a("rst1",      1, 0, 0, 0, 0,            0, 0, 0,    0, 0, 0, 0);
    step_a("rd_3_7",    0, 1, 0, 0, 0,            0, 0, 0,    0, 0, 3, 7);
    step_a("wr_r5",     0, 1, 1, 5, 32'hDEADBEEF, 0, 0, 0,    0, 0, 3, 7);
    step_a("rd_r5",     0, 1, 0, 0, 0,            0, 0, 0,    0, 0, 5, 5);
    step_a("wr_r0",     0, 1, 1, 0, 32'h1234,     0, 0, 0,    0, 0, 0, 5);
    step_a("rd_r0",     0, 1, 0, 0, 0,            0, 0, 0,    0, 0, 0, 5);
    step_a("prio_byp",  0, 1, 1, 9, 32'h11,       1, 9, 32'h22, 0, 0, 9, 9);
    step_a("prio_rd",   0, 1, 0, 0, 0,            0, 0, 0,    0, 0, 9, 0);
    step_a("sb_set",    0, 1, 0, 0, 0,            0, 0, 0,    1, 4, 4, 4);
    step_a("sb_busy",   0, 1, 0, 0, 0,            0, 0, 0,    0, 0, 4, 0);
    step_a("sb_clr",    0, 1, 0, 0, 0,            1, 4, 32'hAB, 0, 0, 4, 4);
    step_a("sb_setwr",  0, 1, 1, 4, 32'h77,       0, 0, 0,    1, 4, 4, 4);
    step_a("sb_hold",   0, 1, 0, 0, 0,            0, 0, 0,    0, 0, 0, 4);
    step_a("stall0",    0, 0, 1, 2, 32'h55,       0, 0, 0,    0, 0, 2, 2);
    step_a("stall1",    0, 0, 0, 0, 0,            0, 0, 0,    1, 7, 7, 1);
    step_a("stall2",    0, 0, 0, 0, 0,            1, 3, 32'h9, 0, 0, 3, 9);
    step_a("stall_rd",  0, 1, 0, 0, 0,            0, 0, 0,    0, 0, 2, 7);
    step_a("mid_set",   0, 1, 0, 0, 0,            0, 0, 0,    1, 6, 6, 0);
    step_a("mid_rst",   1, 1, 1, 6, 32'hCAFE,     0, 0, 0,    1, 6, 6, 6);
    step_a("mid_rd",    0, 1, 0, 0, 0,            0, 0, 0,    0, 0, 6, 7);

    // Random traffic on a narrow address window to force collisions
    for (int k = 0; k < 300; k++) begin
      step_a("rand", ($urandom_range(0, 60) == 0), ($urandom_range(0, 4) != 0),
             1'($urandom), 5'($urandom_range(0, 7)), $urandom,
             1'($urandom), 5'($urandom_range(0, 7)), $urandom,
             1'($urandom), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    a_reset = 1'b1; a_en = 1'b0; a_w0e = 1'b0; a_w1e = 1'b0; a_sbe = 1'b0;

    // tag, rst, en, w0e, w0s, w0d, w1e, w1s, w1d, sbe, sbs, sel{p3..p0}, exp data, exp rdy
    step_b("b_rst0",   1, 0, 0, 0, 0,        0, 0, 0,        0, 0, 16'h0000, 64'h0, 4'hF);
    step_b("b_rst1",   1, 0, 0, 0, 0,        0, 0, 0,        0, 0, 16'h0000, 64'h0, 4'hF);
    step_b("b_wr6",    0, 1, 1, 6, 16'hBEEF, 0, 0, 0,        0, 0, 16'h6066,
           64'hBEEF_0000_BEEF_BEEF, 4'hF);
    step_b("b_set6",   0, 1, 0, 0, 0,        0, 0, 0,        1, 6, 16'h6666,
           64'hBEEF_BEEF_BEEF_BEEF, 4'h0);
    step_b("b_midrst", 1, 1, 0, 0, 0,        1, 6, 16'h1234, 1, 6, 16'h6666, 64'h0, 4'hF);
    step_b("b_rd6",    0, 1, 0, 0, 0,        0, 0, 0,        0, 0, 16'h6666, 64'h0, 4'hF);
    step_b("b_stall",  0, 0, 1, 3, 16'h0042, 0, 0, 0,        0, 0, 16'h3333, 64'h0, 4'hF);
    step_b("b_rd3",    0, 1, 0, 0, 0,        0, 0, 0,        0, 0, 16'h3130,
           64'h0042_0000_0042_0000, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port CPU register file; successor to the single-write, two-read register bank.
- Configurable data width, depth and read-port count. Two write ports with fixed priority.
- Registered reads with write-to-read bypass, and a per-register busy scoreboard for in-flight results.
- Sits between decode (read/scoreboard issue) and writeback (two retire lanes) in the CPU datapath.

Parameters:
DATA_W, 32, width of each register and data bus
ADDR_W, 5, register select width; DEPTH = 2**ADDR_W registers
NUM_RD, 2, number of read ports (1..4)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous active-high reset
en  in  1  read-stage enable; 0 = hold all read outputs (stall)
rd_sel  in  NUM_RD*ADDR_W  read selects, port i at bits [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  registered read data, port i at [i*DATA_W +: DATA_W]
rd_rdy  out  NUM_RD  registered ready flag per read port (1 = data valid, not pending)
wr0_en  in  1  write port 0 enable
wr0_sel  in  ADDR_W  write port 0 address
wr0_data  in  DATA_W  write port 0 data
wr1_en  in  1  write port 1 enable (higher priority)
wr1_sel  in  ADDR_W  write port 1 address
wr1_data  in  DATA_W  write port 1 data
sb_set_en  in  1  mark register busy (instruction issued with this destination)
sb_set_sel  in  ADDR_W  register to mark busy

Behaviour:
- Reset (reset=1 at clk edge): all registers 0; all busy bits 0; rd_data 0; rd_rdy all 1. Reset overrides every other input in that cycle, including any write or set in flight.
- Register 0 is hardwired zero:
  - writes to address 0 are discarded;
  - sb_set to 0 is ignored;
  - a read of address 0 returns 0 with rdy=1.
- Writes occur every cycle regardless of en. wrX_en=1 and wrX_sel!=0 updates the register at the clock edge.
- Both write ports to the same nonzero address in the same cycle: wr1_data is stored; wr0 is dropped.
- Read latency is 1 cycle. When en=1, each port i at the clock edge captures rd_data[i] by priority:
  - sel==0 -> 0;
  - else wr1 write to sel this cycle -> wr1_data;
  - else wr0 write to sel this cycle -> wr0_data;
  - else the stored register value.
- When en=0, rd_data and rd_rdy hold their previous values; the array and scoreboard still update.
- Scoreboard next state for each nonzero register r:
  - busy_next = 1 if sb_set_en and sb_set_sel==r;
  - else 0 if any write to r this cycle;
  - else busy unchanged.
  - Set beats clear: retiring an older writer while issuing a newer one leaves the register busy.
- rd_rdy[i], captured when en=1:
  - 1 if sel==0;
  - else 0 if sb_set to sel this cycle;
  - else 1 if a write to sel this cycle;
  - else !busy[sel].
  - rd_rdy therefore equals the busy state after the edge, consistent with the captured rd_data.
- All read ports are independent. Identical selects on several ports return identical data and rdy.
- No X propagation: every register and output is defined after the first reset.

Test Plan:
- Reset then read: reset=1 for 2 cycles, then en=1, rd_sel={3,7} -> rd_data=0 on both ports, rd_rdy=2'b11 one cycle after the select.
- Write/read latency: wr0 writes 0xDEADBEEF to r5 at cycle N; read r5 at N+1 -> rd_data=0xDEADBEEF at N+2. Write to r0 with 0x1234 -> later read of r0 returns 0.
- Bypass and priority: same cycle, wr0 (r9, 0x11), wr1 (r9, 0x22), read r9 -> rd_data=0x22 after one edge; next read of r9 -> 0x22.
- Scoreboard: sb_set r4 -> read r4 gives rdy=0. Later wr1 writes r4=0xAB with read r4 the same cycle -> rdy=1, data=0xAB. Simultaneous sb_set r4 and wr0 r4 -> rdy=0, data stored.
- Stall: en=0 for 3 cycles while wr0 writes r2=0x55 and the selects change -> rd_data and rd_rdy frozen. en=1 with sel=r2 -> 0x55.
- Reset mid-operation: busy r6 set, write to r6 pending, reset=1 in the same cycle -> r6=0, not busy, outputs zero and rdy all 1 next cycle. Repeat with NUM_RD=4, DATA_W=16, ADDR_W=4.
